// File: rtl/data_sync_v2.sv
// Destination-side CDC bus synchronizer. A qualifier bit is re-timed through a flop chain
// and edge-detected; each detected event captures the source bus and emits a one-cycle pulse.
module data_sync_v2 #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TOGGLE_MODE = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] Unsync_Bus,
    input  logic                 Bus_Enable,
    input  logic                 Ovr_Clr,
    output logic [BUS_WIDTH-1:0] Sync_Bus,
    output logic                 Enable_Pulse,
    output logic                 Sync_Busy,
    output logic                 Overrun,
    output logic [CNT_WIDTH-1:0] Xfer_Count
);

    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("data_sync_v2: NUM_STAGES must be in 2..4");
        end
    endgenerate

    // Handshake: Bus_Enable acts as a valid with no ready. The source holds Unsync_Bus
    // stable from the qualifier change until Enable_Pulse rises; a new qualifier event
    // arriving while the previous one is still in the chain is flagged as Overrun.

    logic [NUM_STAGES-1:0] sync_q;
    logic                  edge_q;
    logic                  sync_last;
    logic                  event_w;
    logic                  entry_w;
    logic [NUM_STAGES:0]   chain_w;

    assign sync_last = sync_q[NUM_STAGES-1];
    assign chain_w   = {sync_q, edge_q};

    always_comb begin
        event_w = 1'b0;
        entry_w = 1'b0;
        if (TOGGLE_MODE != 0) begin
            event_w = sync_last ^ edge_q;
            entry_w = Bus_Enable ^ sync_q[0];
        end else begin
            event_w = sync_last & ~edge_q;
            entry_w = Bus_Enable & ~sync_q[0];
        end
    end

    // Busy while any chain flop disagrees with the others, i.e. a change is still travelling.
    assign Sync_Busy = (|chain_w) & ~(&chain_w);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], Bus_Enable};
            edge_q <= sync_last;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Sync_Bus     <= '0;
            Enable_Pulse <= 1'b0;
            Xfer_Count   <= '0;
        end else begin
            Enable_Pulse <= event_w;
            if (event_w) begin
                Sync_Bus   <= Unsync_Bus;
                Xfer_Count <= Xfer_Count + CNT_WIDTH'(1);
            end
        end
    end

    // Set takes priority over clear so an overrun coinciding with Ovr_Clr is not lost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Overrun <= 1'b0;
        end else if (entry_w && Sync_Busy) begin
            Overrun <= 1'b1;
        end else if (Ovr_Clr) begin
            Overrun <= 1'b0;
        end
    end

endmodule

// File: doc/data_sync_v2.md
# data_sync_v2

Parametrised successor to the bus data synchronizer. It sits on the destination-clock side of a clock-domain crossing. A single enable/qualifier bit passes through a configurable-depth flop chain and is edge-detected; on each detected event the block captures the quasi-static source bus into a destination register and emits a one-cycle enable pulse. Over the base synchronizer it adds:
- selectable level/toggle qualifier mode
- an in-flight busy indicator
- sticky overrun detection with clear
- a wrapping transfer counter

## Interface
- BUS_WIDTH, 8, width of data bus
- NUM_STAGES, 2, synchronizer flop count on qualifier path; legal range 2..4
- TOGGLE_MODE, 0, 0 = level/rising-edge qualifier, 1 = toggle qualifier (every level change is one transfer)
- CNT_WIDTH, 8, width of transfer counter
- CLK  input  1  destination clock, rising edge
- RST  input  1  reset, asynchronous assert, active-low
- Unsync_Bus  input  BUS_WIDTH  source-domain data, stable while its qualifier is in flight
- Bus_Enable  input  1  source-domain qualifier (level or toggle per TOGGLE_MODE)
- Ovr_Clr  input  1  synchronous clear of Overrun, destination domain
- Sync_Bus  output  BUS_WIDTH  captured data, registered
- Enable_Pulse  output  1  one-cycle pulse, coincident with Sync_Bus update
- Sync_Busy  output  1  qualifier change in flight through chain
- Overrun  output  1  sticky: new qualifier event entered while previous still in flight
- Xfer_Count  output  CNT_WIDTH  number of completed transfers, wraps

## Operation
- Reset (RST low, async): all sync stages, edge flop, Sync_Bus, Enable_Pulse, Overrun and Xfer_Count go to 0. Sync_Busy reads 0 because every flop equals 0.
- Qualifier chain:
  - s[0] <= Bus_Enable, then s[i] <= s[i-1] for i = 1..NUM_STAGES-1.
  - Edge flop: e <= s[NUM_STAGES-1].
- Event (combinational):
  - TOGGLE_MODE=0: s[last] & ~e.
  - TOGGLE_MODE=1: s[last] ^ e.
- On event at a clock edge:
  - Sync_Bus <= Unsync_Bus.
  - Enable_Pulse <= 1.
  - Xfer_Count <= Xfer_Count+1, modulo 2^CNT_WIDTH.
- Otherwise Enable_Pulse <= 0 and Sync_Bus holds its value.
- Sync_Busy = 1 whenever the values {s[0..last], e} are not all equal; it is combinational from registers.
- Entry detect, evaluated at stage 0:
  - TOGGLE_MODE=0: Bus_Enable & ~s[0].
  - TOGGLE_MODE=1: Bus_Enable ^ s[0].
- Overrun:
  - Set on an edge where entry detect is 1 and Sync_Busy is 1.
  - Ovr_Clr clears it.
  - Set and clear in the same cycle: set wins.
- Level mode:
  - Bus_Enable held high for many cycles gives exactly one pulse.
  - A new transfer needs Bus_Enable low for at least 1 cycle.
- Source obligation: Unsync_Bus is stable from qualifier change until Enable_Pulse rises. The block does not check this.
- NUM_STAGES outside 2..4 is a parameter error and is flagged at elaboration.

## Timing
- Latency, with the qualifier change set up before edge 1:
  - s[last] updates at edge NUM_STAGES.
  - The event is true in the following cycle.
  - Sync_Bus, Enable_Pulse and Xfer_Count update at edge NUM_STAGES+1.
  - For NUM_STAGES=2: ready after 2 edges, output on the 3rd.
- Enable_Pulse is exactly 1 cycle wide per event. In toggle mode, back-to-back toggles spaced at least 1 cycle apart each yield a pulse.
- Sync_Busy:
  - Rises the cycle after s[0] captures a new value.
  - Falls at the edge where e catches s[last], which is NUM_STAGES+1 edges after entry.
- Overrun is visible the cycle after the offending entry edge.
- Reset mid-transfer discards the in-flight transfer: no pulse after release and Xfer_Count=0. If Bus_Enable is still high after release in level mode, it is treated as a new transfer.
- Xfer_Count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Test plan
- Reset: hold RST low 1 cycle with Bus_Enable=1 -> all outputs 0 during reset; Sync_Busy=0.
- Level mode, NUM_STAGES=2: apply 0xBE, 0xAC, 0x92, each with Bus_Enable high 1 cycle and 3 idle cycles between -> each appears on Sync_Bus at the 3rd edge with a 1-cycle Enable_Pulse; Xfer_Count=3; Overrun=0.
- Level mode, Bus_Enable held high 6 cycles with 0x5A -> exactly one pulse; Sync_Bus=0x5A; Xfer_Count=1.
- Overrun: Bus_Enable pulses at cycle 0 and cycle 2 (0x11, then 0x22) -> Overrun=1 from cycle 3; Ovr_Clr for 1 cycle -> Overrun=0. Assert Ovr_Clr on the same edge as a new overrun -> Overrun stays 1.
- TOGGLE_MODE=1, NUM_STAGES=3: toggle Bus_Enable 0->1->0 two cycles apart with 0xC3 then 0x3C -> two pulses, each 4 edges after its toggle; Xfer_Count=2.
- CNT_WIDTH=2: five transfers -> Xfer_Count reads 1. Reset asserted at edge 2 of an in-flight transfer -> no Enable_Pulse and Sync_Bus=0 after release.
